// File: rtl/wash_cycle_controller.sv
// -----------------------------------------------------------------------------
// wash_cycle_controller
//
// Sequences one washing-machine cycle:
//   IDLE -> FILL -> WASH -> DRAIN -> (FILL -> RINSE -> DRAIN) x NUM_RINSE
//        -> SPIN -> DONE -> IDLE
// Any fault lands in FAULT. FAULT is left only through Reset.
//
// Ports
//   Clock            : sole clock. All state changes on the rising edge.
//   Reset            : synchronous, active-high.
//   Start            : level. Requests a cycle while in IDLE.
//   Door_Close       : 1 = door shut.
//   Filled, Drained  : tub level sensors (full / empty).
//   Detergent_Added  : pulse or level. Detergent is present.
//   Pause            : level. Freezes progress while high.
//   Motor_on, Fill_valve_on, Drained_valve_on : actuator drives.
//   Door_Lock, Done, Fault                    : status lines.
//   State            : IDLE=0 FILL=1 WASH=2 DRAIN=3 RINSE=4 SPIN=5 DONE=6
//                      FAULT=7.
//   Rinse_Count      : rinse passes completed in the current cycle.
// -----------------------------------------------------------------------------
module wash_cycle_controller #(
  parameter int WASH_TICKS    = 8,
  parameter int RINSE_TICKS   = 4,
  parameter int SPIN_TICKS    = 6,
  parameter int NUM_RINSE     = 2,
  parameter int LEVEL_TIMEOUT = 16,
  parameter int TMR_W         = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Door_Close,
  input  logic       Filled,
  input  logic       Drained,
  input  logic       Detergent_Added,
  input  logic       Pause,
  output logic       Motor_on,
  output logic       Fill_valve_on,
  output logic       Drained_valve_on,
  output logic       Door_Lock,
  output logic       Done,
  output logic       Fault,
  output logic [2:0] State,
  output logic [3:0] Rinse_Count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_RINSE = 3'd4,
    S_SPIN  = 3'd5,
    S_DONE  = 3'd6,
    S_FAULT = 3'd7
  } state_e;

  // Terminal timer values. A phase ends on the cycle in which the timer
  // shows its last value.
  localparam logic [TMR_W-1:0] WASH_LAST  = TMR_W'(WASH_TICKS - 1);
  localparam logic [TMR_W-1:0] RINSE_LAST = TMR_W'(RINSE_TICKS - 1);
  localparam logic [TMR_W-1:0] SPIN_LAST  = TMR_W'(SPIN_TICKS - 1);
  localparam logic [TMR_W-1:0] LEVEL_LAST = TMR_W'(LEVEL_TIMEOUT - 1);
  localparam logic [3:0]       RINSE_MAX  = 4'(NUM_RINSE);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       rinse_q, rinse_d;
  logic             flag_q, flag_d;
  logic             drained_q;
  logic             busy;

  // The door-locked phases FILL..SPIN share the door-open fault rule.
  assign busy = (state_q == S_FILL)  || (state_q == S_WASH) ||
                (state_q == S_DRAIN) || (state_q == S_RINSE) ||
                (state_q == S_SPIN);

  // Next-state logic. Pause suppresses every timer- and sensor-driven move.
  // An open door overrides all of it, so that check comes last. The timer
  // restarts on every state change. In WASH it only counts once detergent
  // is in. This way a late detergent pulse still yields a full wash.
  always_comb begin
    state_d = state_q;
    rinse_d = rinse_q;
    flag_d  = flag_q;
    timer_d = timer_q;

    if (((state_q == S_FILL) || (state_q == S_WASH)) && Detergent_Added)
      flag_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        rinse_d = 4'd0;
        flag_d  = 1'b0;
        if (Start && Door_Close)
          state_d = S_FILL;
      end
      S_FILL: begin
        if (!Pause) begin
          if (Filled)
            state_d = (rinse_q == 4'd0) ? S_WASH : S_RINSE;
          else if (timer_q == LEVEL_LAST)
            state_d = S_FAULT;
        end
      end
      S_WASH: begin
        if (!Pause && flag_q && (timer_q == WASH_LAST))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!Pause) begin
          if (Drained) begin
            if (rinse_q < RINSE_MAX) begin
              state_d = S_FILL;
              rinse_d = rinse_q + 4'd1;
            end else begin
              state_d = S_SPIN;
            end
          end else if (timer_q == LEVEL_LAST) begin
            state_d = S_FAULT;
          end
        end
      end
      S_RINSE: begin
        if (!Pause && (timer_q == RINSE_LAST))
          state_d = S_DRAIN;
      end
      S_SPIN: begin
        if (!Pause && (timer_q == SPIN_LAST))
          state_d = S_DONE;
      end
      S_DONE: begin
        if (!Door_Close)
          state_d = S_IDLE;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (busy && !Door_Close) begin
      state_d = S_FAULT;
      rinse_d = rinse_q;
    end

    if (state_d != state_q)
      timer_d = '0;
    else if (busy && !Pause && ((state_q != S_WASH) || flag_q))
      timer_d = timer_q + 1'b1;
  end

  // State registers. Reset wins over everything. Drained is registered here
  // so the FAULT door lock follows the sensor one cycle late. That keeps
  // every output free of a combinational input path, except Pause.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      rinse_q   <= 4'd0;
      flag_q    <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rinse_q   <= rinse_d;
      flag_q    <= flag_d;
      drained_q <= Drained;
    end
  end

  // Moore output decode. Pause kills the motor and valves in the working
  // phases, but the door stays locked. FAULT keeps the drain open. It also
  // holds the door locked until the tub reads empty.
  always_comb begin
    Motor_on         = 1'b0;
    Fill_valve_on    = 1'b0;
    Drained_valve_on = 1'b0;
    Door_Lock        = busy;
    Done             = (state_q == S_DONE);
    Fault            = (state_q == S_FAULT);
    case (state_q)
      S_FILL:  Fill_valve_on    = !Pause;
      S_WASH:  Motor_on         = !Pause && flag_q;
      S_DRAIN: Drained_valve_on = !Pause;
      S_RINSE: Motor_on         = !Pause;
      S_SPIN: begin
        Motor_on         = !Pause;
        Drained_valve_on = !Pause;
      end
      S_FAULT: begin
        Drained_valve_on = 1'b1;
        Door_Lock        = !drained_q;
      end
      default: begin
        Motor_on = 1'b0;
      end
    endcase
  end

  assign State       = state_q;
  assign Rinse_Count = rinse_q;

endmodule

// File: tb/tb_wash_cycle_controller.sv
// -----------------------------------------------------------------------------
// tb_wash_cycle_controller
//
// Directed bench for wash_cycle_controller. It has two instances:
//   dut  : default parameters.
//   dut0 : NUM_RINSE = 0.
// Both instances share one set of inputs. Only the instance under test in a
// given scenario is checked.
// -----------------------------------------------------------------------------
module tb_wash_cycle_controller;

  logic       Clock = 1'b0;
  logic       Reset, Start, Door_Close, Filled, Drained, Detergent_Added, Pause;
  logic       Motor_on, Fill_valve_on, Drained_valve_on, Door_Lock, Done, Fault;
  logic [2:0] State;
  logic [3:0] Rinse_Count;
  logic       Motor0, Fill0, DrainV0, Lock0, Done0, Fault0;
  logic [2:0] State0;
  logic [3:0] Rinse0;

  int checks = 0;
  int errors = 0;

  logic [2:0] seq[$];
  logic [2:0] seq0[$];
  logic [2:0] lastState, lastState0;

  wash_cycle_controller dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Door_Close(Door_Close),
    .Filled(Filled), .Drained(Drained), .Detergent_Added(Detergent_Added),
    .Pause(Pause), .Motor_on(Motor_on), .Fill_valve_on(Fill_valve_on),
    .Drained_valve_on(Drained_valve_on), .Door_Lock(Door_Lock), .Done(Done),
    .Fault(Fault), .State(State), .Rinse_Count(Rinse_Count)
  );

  wash_cycle_controller #(.NUM_RINSE(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Door_Close(Door_Close),
    .Filled(Filled), .Drained(Drained), .Detergent_Added(Detergent_Added),
    .Pause(Pause), .Motor_on(Motor0), .Fill_valve_on(Fill0),
    .Drained_valve_on(DrainV0), .Door_Lock(Lock0), .Done(Done0),
    .Fault(Fault0), .State(State0), .Rinse_Count(Rinse0)
  );

  // 10-unit clock period.
  always #5 Clock = ~Clock;

  // Advance one rising edge, then settle 1 unit before sampling. Record every
  // state change of both instances.
  task automatic step();
    @(posedge Clock);
    #1;
    if (State !== lastState) seq.push_back(State);
    if (State0 !== lastState0) seq0.push_back(State0);
    lastState  = State;
    lastState0 = State0;
  endtask

  task automatic doReset();
    Reset = 1'b1; Start = 1'b0; Filled = 1'b0; Drained = 1'b0;
    Detergent_Added = 1'b0; Pause = 1'b0; Door_Close = 1'b1;
    step();
    Reset = 1'b0;
    seq.delete(); seq0.delete();
    lastState = 3'd0; lastState0 = 3'd0;
  endtask

  // Play the sensors for whichever instance is selected until it reaches
  // `target`. Returns whether it got there within the budget.
  task automatic runTo(input bit which, input logic [2:0] target,
                       input int budget, output bit reached);
    logic [2:0] cur;
    reached = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cur = which ? State0 : State;
      if (cur === target) begin
        reached = 1'b1;
        break;
      end
      Filled          = (cur == 3'd1);
      Detergent_Added = (cur == 3'd2);
      Drained         = (cur == 3'd3);
      step();
    end
    Filled = 1'b0; Detergent_Added = 1'b0; Drained = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Door_Close = 1'b0; Filled = 1'b0;
    Drained = 1'b0; Detergent_Added = 1'b0; Pause = 1'b0;
    step();
    Reset = 1'b0;
    checks++;
    if (State !== 3'd0 || Rinse_Count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: State=%0d Rinse=%0d, want 0 0", State, Rinse_Count);
    end
    checks++;
    if ({Motor_on, Fill_valve_on, Drained_valve_on, Door_Lock, Done, Fault} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, want 000000",
               {Motor_on, Fill_valve_on, Drained_valve_on, Door_Lock, Done, Fault});
    end
    // Start with the door open must not begin a cycle.
    Start = 1'b1;
    step();
    Start = 1'b0;
    checks++;
    if (State !== 3'd0) begin
      errors++;
      $display("[TB] FAIL start_door_open: State=%0d, want 0", State);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_nominal();
    int cnt;
    bit ok;
    logic [2:0] expSeq[11] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd5, 3'd6};
    doReset();
    Start = 1'b1;
    step();
    Start = 1'b0;
    checks++;
    if (State !== 3'd1 || Fill_valve_on !== 1'b1 || Door_Lock !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_entry: State=%0d fill=%b lock=%b, want 1 1 1",
               State, Fill_valve_on, Door_Lock);
    end
    Filled = 1'b1;
    step();
    Filled = 1'b0;
    checks++;
    if (State !== 3'd2 || Motor_on !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wash_no_detergent: State=%0d motor=%b, want 2 0", State, Motor_on);
    end
    Detergent_Added = 1'b1;
    step();
    Detergent_Added = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && State == 3'd2; i++) begin
      if (Motor_on) cnt++;
      step();
    end
    checks++;
    if (cnt != 8) begin
      errors++;
      $display("[TB] FAIL wash_motor_cycles: got %0d, want 8", cnt);
    end
    checks++;
    if (State !== 3'd3 || Drained_valve_on !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain_entry: State=%0d drainv=%b, want 3 1", State, Drained_valve_on);
    end
    for (int pass = 1; pass <= 2; pass++) begin
      Drained = 1'b1;
      step();
      Drained = 1'b0;
      checks++;
      if (State !== 3'd1 || Rinse_Count !== 4'(pass)) begin
        errors++;
        $display("[TB] FAIL rinse_count_%0d: State=%0d Rinse=%0d, want 1 %0d",
                 pass, State, Rinse_Count, pass);
      end
      Filled = 1'b1;
      step();
      Filled = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20 && State == 3'd4; i++) begin
        if (Motor_on) cnt++;
        step();
      end
      checks++;
      if (cnt != 4) begin
        errors++;
        $display("[TB] FAIL rinse_motor_cycles_%0d: got %0d, want 4", pass, cnt);
      end
    end
    Drained = 1'b1;
    step();
    Drained = 1'b0;
    checks++;
    if (State !== 3'd5 || Motor_on !== 1'b1 || Drained_valve_on !== 1'b1) begin
      errors++;
      $display("[TB] FAIL spin_entry: State=%0d motor=%b drainv=%b, want 5 1 1",
               State, Motor_on, Drained_valve_on);
    end
    cnt = 0;
    for (int i = 0; i < 20 && State == 3'd5; i++) begin
      if (Motor_on) cnt++;
      step();
    end
    checks++;
    if (cnt != 6) begin
      errors++;
      $display("[TB] FAIL spin_motor_cycles: got %0d, want 6", cnt);
    end
    checks++;
    if (State !== 3'd6 || Done !== 1'b1 || Door_Lock !== 1'b0 || Rinse_Count !== 4'd2) begin
      errors++;
      $display("[TB] FAIL done_state: State=%0d done=%b lock=%b rinse=%0d, want 6 1 0 2",
               State, Done, Door_Lock, Rinse_Count);
    end
    ok = (seq.size() == 11);
    if (ok) foreach (expSeq[i]) if (seq[i] !== expSeq[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL nominal_sequence: got %0d states %p, want 11 states %p", seq.size(), seq, expSeq);
    end
    Door_Close = 1'b0;
    step();
    Door_Close = 1'b1;
    checks++;
    if (State !== 3'd0) begin
      errors++;
      $display("[TB] FAIL done_to_idle: State=%0d, want 0", State);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_pause();
    int cnt, zero;
    bit held;
    doReset();
    Start = 1'b1;
    step();
    Start = 1'b0;
    // Pause in FILL: Filled must be ignored and the valve shut.
    Pause = 1'b1; Filled = 1'b1;
    step();
    checks++;
    if (State !== 3'd1 || Fill_valve_on !== 1'b0 || Door_Lock !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pause_fill: State=%0d fill=%b lock=%b, want 1 0 1",
               State, Fill_valve_on, Door_Lock);
    end
    Pause = 1'b0;
    step();
    Filled = 1'b0;
    Detergent_Added = 1'b1;
    step();
    Detergent_Added = 1'b0;
    cnt = 0;
    repeat (3) begin
      if (Motor_on) cnt++;
      step();
    end
    Pause = 1'b1;
    #1;
    zero = 0;
    held = 1'b1;
    repeat (5) begin
      if (!Motor_on) zero++;
      if (State !== 3'd2 || Door_Lock !== 1'b1) held = 1'b0;
      step();
    end
    Pause = 1'b0;
    #1;
    checks++;
    if (zero != 5 || !held) begin
      errors++;
      $display("[TB] FAIL pause_wash: motor-off cycles %0d held=%b, want 5 1", zero, held);
    end
    for (int i = 0; i < 20 && State == 3'd2; i++) begin
      if (Motor_on) cnt++;
      step();
    end
    checks++;
    if (cnt != 8 || State !== 3'd3) begin
      errors++;
      $display("[TB] FAIL pause_wash_total: motor cycles %0d State=%0d, want 8 3", cnt, State);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fill_timeout();
    int n;
    doReset();
    Start = 1'b1;
    step();
    Start = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && State == 3'd1; i++) begin
      n++;
      step();
    end
    checks++;
    if (n != 16 || State !== 3'd7) begin
      errors++;
      $display("[TB] FAIL fill_timeout: %0d cycles in FILL, State=%0d, want 16 7", n, State);
    end
    checks++;
    if (Fault !== 1'b1 || Drained_valve_on !== 1'b1 || Door_Lock !== 1'b1 ||
        Motor_on !== 1'b0 || Fill_valve_on !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_outputs: fault=%b drainv=%b lock=%b motor=%b fill=%b, want 1 1 1 0 0",
               Fault, Drained_valve_on, Door_Lock, Motor_on, Fill_valve_on);
    end
    Drained = 1'b1;
    #1;
    checks++;
    if (Door_Lock !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fault_lock_before_edge: lock=%b, want 1", Door_Lock);
    end
    step();
    checks++;
    if (Door_Lock !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_lock_release: lock=%b, want 0", Door_Lock);
    end
    Start = 1'b1;
    step();
    Start = 1'b0;
    Drained = 1'b0;
    checks++;
    if (State !== 3'd7) begin
      errors++;
      $display("[TB] FAIL fault_sticky: State=%0d, want 7", State);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_door_open();
    bit reached;
    doReset();
    Start = 1'b1;
    step();
    Start = 1'b0;
    runTo(1'b0, 3'd4, 100, reached);
    step();
    checks++;
    if (!reached || State !== 3'd4 || Motor_on !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reach_rinse: reached=%b State=%0d motor=%b, want 1 4 1",
               reached, State, Motor_on);
    end
    Door_Close = 1'b0;
    step();
    Door_Close = 1'b1;
    checks++;
    if (State !== 3'd7 || Motor_on !== 1'b0 || Fault !== 1'b1) begin
      errors++;
      $display("[TB] FAIL door_open_rinse: State=%0d motor=%b fault=%b, want 7 0 1",
               State, Motor_on, Fault);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_spin();
    bit reached, ok;
    logic [2:0] expSeq[11] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd5, 3'd6};
    doReset();
    Start = 1'b1;
    step();
    Start = 1'b0;
    runTo(1'b0, 3'd5, 150, reached);
    step();
    step();
    checks++;
    if (!reached || State !== 3'd5 || Motor_on !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reach_spin: reached=%b State=%0d motor=%b, want 1 5 1",
               reached, State, Motor_on);
    end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++;
    if (State !== 3'd0 || Rinse_Count !== 4'd0 ||
        {Motor_on, Fill_valve_on, Drained_valve_on, Door_Lock, Done, Fault} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_spin: State=%0d rinse=%0d outs=%b, want 0 0 000000", State,
               Rinse_Count, {Motor_on, Fill_valve_on, Drained_valve_on, Door_Lock, Done, Fault});
    end
    seq.delete();
    lastState = State;
    Start = 1'b1;
    step();
    Start = 1'b0;
    runTo(1'b0, 3'd6, 200, reached);
    ok = reached && (seq.size() == 11);
    if (ok) foreach (expSeq[i]) if (seq[i] !== expSeq[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL rerun_sequence: reached=%b got %0d states %p, want 11 states %p",
               reached, seq.size(), seq, expSeq);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_no_rinse();
    bit reached, ok;
    logic [2:0] expSeq[5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
    doReset();
    Start = 1'b1;
    step();
    Start = 1'b0;
    runTo(1'b1, 3'd6, 150, reached);
    ok = reached && (seq0.size() == 5);
    if (ok) foreach (expSeq[i]) if (seq0[i] !== expSeq[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL no_rinse_sequence: reached=%b got %0d states %p, want 5 states %p",
               reached, seq0.size(), seq0, expSeq);
    end
    checks++;
    if (Rinse0 !== 4'd0 || Done0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL no_rinse_done: rinse=%0d done=%b, want 0 1", Rinse0, Done0);
    end
  endtask

  // Scenario sequence, then the single summary line.
  initial begin
    lastState = 3'd0;
    lastState0 = 3'd0;
    test_reset();
    test_nominal();
    test_pause();
    test_fill_timeout();
    test_door_open();
    test_reset_spin();
    test_no_rinse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a scenario stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time expired, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/wash_cycle_controller.md
WASH_CYCLE_CONTROLLER -- requirements
Module: wash_cycle_controller

Interface
REQ-001 Parameter WASH_TICKS, default 8, sets the unpaused WASH duration in cycles (>=1).
REQ-002 Parameter RINSE_TICKS, default 4, sets the unpaused RINSE duration in cycles (>=1).
REQ-003 Parameter SPIN_TICKS, default 6, sets the unpaused SPIN duration in cycles (>=1).
REQ-004 Parameter NUM_RINSE, default 2, sets the rinse passes per cycle (0..15).
REQ-005 Parameter LEVEL_TIMEOUT, default 16, sets the max unpaused cycles in FILL or DRAIN before fault (>=2).
REQ-006 Parameter TMR_W, default 8, sets the timer width and SHALL hold max(all TICKS, LEVEL_TIMEOUT).
REQ-007 Clock  in  1  sole clock; all state updates on the rising edge.
REQ-008 Reset  in  1  synchronous, active-high.
REQ-009 Start  in  1  level; requests a cycle from IDLE.
REQ-010 Door_Close  in  1  1 = door shut.
REQ-011 Filled  in  1  level sensor; tub full.
REQ-012 Drained  in  1  level sensor; tub empty.
REQ-013 Detergent_Added  in  1  pulse or level; detergent present.
REQ-014 Pause  in  1  level; freezes progress while high.
REQ-015 Motor_on, Fill_valve_on, Drained_valve_on, Door_Lock, Done, Fault  out  1 each  actuator and status lines.
REQ-016 State  out  3  IDLE=0 FILL=1 WASH=2 DRAIN=3 RINSE=4 SPIN=5 DONE=6 FAULT=7.
REQ-017 Rinse_Count  out  4  rinse passes completed in the current cycle.

Function
REQ-018 Outputs SHALL be Moore-decoded from the State register, a sticky detergent flag and Pause only; no input-to-output combinational path other than Pause.
REQ-019 The timer SHALL clear on every state change, increment once per unpaused cycle, and hold while Pause=1.
REQ-020 IDLE: all outputs 0; Start=1 and Door_Close=1 in the same cycle -> FILL next cycle; Rinse_Count and the detergent flag clear.
REQ-021 FILL: Fill_valve_on=1; Filled=1 -> WASH if Rinse_Count==0, else RINSE.
REQ-022 FILL timeout: timer reaching LEVEL_TIMEOUT-1 with Filled=0 -> FAULT.
REQ-023 WASH: Motor_on=1 only once the detergent flag is set (flag set by Detergent_Added=1 in FILL or WASH).
REQ-024 WASH timer SHALL advance only while the flag is set; timer==WASH_TICKS-1 -> DRAIN.
REQ-025 DRAIN: Drained_valve_on=1; Drained=1 -> FILL with Rinse_Count+1 if Rinse_Count<NUM_RINSE, else SPIN.
REQ-026 DRAIN SHALL apply the same LEVEL_TIMEOUT rule to FAULT as FILL.
REQ-027 Rinse_Count increments only on DRAIN->FILL; NUM_RINSE=0 goes directly DRAIN->SPIN after the wash.
REQ-028 RINSE: Motor_on=1; timer==RINSE_TICKS-1 -> DRAIN.
REQ-029 SPIN: Motor_on=1 and Drained_valve_on=1; timer==SPIN_TICKS-1 -> DONE.
REQ-030 DONE: Done=1 and Door_Lock=0; Door_Close=0 -> IDLE.
REQ-031 Door_Lock=1 in FILL, WASH, DRAIN, RINSE and SPIN.
REQ-032 Pause=1 in FILL..SPIN: Motor_on, Fill_valve_on and Drained_valve_on forced 0; state held; Door_Lock stays 1; sensor-driven transitions suppressed.
REQ-033 Door_Close=0 in FILL..SPIN (paused or not) -> FAULT next cycle; this takes priority over every other transition.
REQ-034 FAULT: Fault=1, Motor_on=0, Fill_valve_on=0, Drained_valve_on=1.
REQ-035 In FAULT, Door_Lock SHALL equal ~Drained; only Reset exits FAULT.
REQ-036 Start while busy, and Detergent_Added outside FILL or WASH, SHALL be ignored.

Reset
REQ-037 Reset=1 at a clock edge -> State=IDLE, timer=0, Rinse_Count=0, flag=0, all 1-bit outputs 0, from any state including mid-SPIN and FAULT.
REQ-038 Reset SHALL take priority over all inputs.

Verification
REQ-039 Nominal run with defaults, no Pause: Start+Door_Close, Filled, Detergent_Added, Drained pulses -> states 1,2,3,1,4,3,1,4,3,5,6; WASH Motor_on 8 cycles, each RINSE 4, SPIN 6; Rinse_Count ends 2; Done=1.
REQ-040 Pause for 5 cycles at WASH timer=3 -> Motor_on 0 for exactly 5 cycles; total WASH Motor_on still 8 cycles; State stays 2 throughout.
REQ-041 Filled never asserted -> FAULT after exactly 16 cycles in FILL; Fault=1 and Drained_valve_on=1; Door_Lock drops the cycle after Drained=1.
REQ-042 Door_Close=0 during RINSE -> State=7 next cycle; Motor_on=0.
REQ-043 Reset mid-SPIN -> next cycle State=0 and all outputs 0; a new Start runs the full sequence again.
REQ-044 NUM_RINSE=0 build -> sequence 1,2,3,5,6 with Rinse_Count staying 0.
